gpio_controller_v2: RTL and testbench

//   Parametrised Wishbone GPIO port: GPIO_WIDTH pins with per-pin direction, atomic set/clear,

---
 rtl/gpio_controller_v2.sv | 250 +++++++++++++++++++++++++
 tb/tb_gpio_controller_v2.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_controller_v2.sv
// ---------------------------------------------------------------------------
// gpio_controller_v2
//
// Wishbone GPIO port with GPIO_WIDTH pins. Each pin has a direction bit,
// an output data bit with atomic set/clear aliases, a multi-flop input
// synchroniser, and per-pin rising/falling edge interrupt latching.
//
// Parameters
//   BASE_ADDR    register block base address (full 32-bit compare)
//   GPIO_WIDTH   number of pins, 1..32
//   SYNC_STAGES  input synchroniser depth, >= 2
//
// Ports
//   clk        system / Wishbone clock
//   rst_n      asynchronous active-low reset
//   wb_dat_i   write data
//   wb_dat_o   read data, registered, valid with wb_ack_o
//   wb_adr_i   byte address
//   wb_we_i    1 = write, 0 = read
//   wb_stb_i   strobe
//   wb_cyc_i   cycle valid
//   wb_ack_o   acknowledge, registered, one cycle per access
//   gpio_i     asynchronous pin inputs
//   gpio_o     output data (ODR)
//   gpio_oe    output enable (DIR, 1 = drive)
//   irq        level interrupt, OR of the interrupt status register
//
// Register map (offset from BASE_ADDR)
//   0x00 IDR  RO     synchronised pin state
//   0x04 ODR  RW     output data
//   0x08 DIR  RW     direction
//   0x0C SET  WO     ODR |= wdata, reads 0
//   0x10 CLR  WO     ODR &= ~wdata, reads 0
//   0x14 RISE RW     rising-edge interrupt enable
//   0x18 FALL RW     falling-edge interrupt enable
//   0x1C ISR  R/W1C  interrupt status
//   Bits at or above GPIO_WIDTH read 0 and ignore writes. Any other
//   address is acked; reads return all ones and writes are dropped.
// ---------------------------------------------------------------------------
module gpio_controller_v2 #(
   parameter logic [31:0] BASE_ADDR   = 32'h8000_1000,
   parameter int          GPIO_WIDTH  = 16,
   parameter int          SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [31:0]           wb_dat_i,
   output logic [31:0]           wb_dat_o,
   input  logic [31:0]           wb_adr_i,
   input  logic                  wb_we_i,
   input  logic                  wb_stb_i,
   input  logic                  wb_cyc_i,
   output logic                  wb_ack_o,
   input  logic [GPIO_WIDTH-1:0] gpio_i,
   output logic [GPIO_WIDTH-1:0] gpio_o,
   output logic [GPIO_WIDTH-1:0] gpio_oe,
   output logic                  irq
);

   // Absolute register addresses
   localparam logic [31:0] ADR_IDR  = BASE_ADDR + 32'h0000_0000;
   localparam logic [31:0] ADR_ODR  = BASE_ADDR + 32'h0000_0004;
   localparam logic [31:0] ADR_DIR  = BASE_ADDR + 32'h0000_0008;
   localparam logic [31:0] ADR_SET  = BASE_ADDR + 32'h0000_000C;
   localparam logic [31:0] ADR_CLR  = BASE_ADDR + 32'h0000_0010;
   localparam logic [31:0] ADR_RISE = BASE_ADDR + 32'h0000_0014;
   localparam logic [31:0] ADR_FALL = BASE_ADDR + 32'h0000_0018;
   localparam logic [31:0] ADR_ISR  = BASE_ADDR + 32'h0000_001C;

   localparam logic [GPIO_WIDTH-1:0] PIN_ZERO = {GPIO_WIDTH{1'b0}};

   // Zero-extend a pin-wide value to the 32-bit bus. Written as a function so
   // GPIO_WIDTH = 32 needs no zero-width replication.
   function automatic logic [31:0] pad32(input logic [GPIO_WIDTH-1:0] v);
      logic [31:0] r;
      r = 32'h0000_0000;
      r[GPIO_WIDTH-1:0] = v;
      return r;
   endfunction

   // ------------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0][GPIO_WIDTH-1:0] sync_chain;
   logic [GPIO_WIDTH-1:0] sync_pins;
   logic [GPIO_WIDTH-1:0] prev_pins;
   logic [GPIO_WIDTH-1:0] rise_evt;
   logic [GPIO_WIDTH-1:0] fall_evt;

   logic [GPIO_WIDTH-1:0] odr;
   logic [GPIO_WIDTH-1:0] odr_next;
   logic [GPIO_WIDTH-1:0] dir;
   logic [GPIO_WIDTH-1:0] rise_en;
   logic [GPIO_WIDTH-1:0] fall_en;
   logic [GPIO_WIDTH-1:0] isr;
   logic [GPIO_WIDTH-1:0] w1c_mask;

   logic                  access;
   logic                  wr_en;
   logic [GPIO_WIDTH-1:0] wdata;
   logic [31:0]           read_data;

   // Upper write-data bits are deliberately dropped when GPIO_WIDTH < 32
   logic                  unused_wdata;

   assign unused_wdata = ^wb_dat_i;

   // ------------------------------------------------------------------------
   // Bus qualification
   // ------------------------------------------------------------------------
   // Gating with ~wb_ack_o makes a held strobe produce one access every two
   // cycles instead of a second access on the ack cycle.
   assign access = wb_cyc_i & wb_stb_i & ~wb_ack_o;
   assign wr_en  = access & wb_we_i;
   assign wdata  = wb_dat_i[GPIO_WIDTH-1:0];

   // ------------------------------------------------------------------------
   // Input path
   // ------------------------------------------------------------------------
   assign sync_pins = sync_chain[SYNC_STAGES-1];

   // Synchroniser shift chain plus one-cycle history for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_chain <= {SYNC_STAGES{PIN_ZERO}};
         prev_pins  <= PIN_ZERO;
      end else begin
         sync_chain <= {sync_chain[SYNC_STAGES-2:0], gpio_i};
         prev_pins  <= sync_pins;
      end
   end

   // Enabled edge events; enables gate only the event, never the history,
   // so turning an enable on cannot latch an edge that already happened.
   always_comb begin
      rise_evt = sync_pins & ~prev_pins & rise_en;
      fall_evt = ~sync_pins & prev_pins & fall_en;
   end

   // ------------------------------------------------------------------------
   // Register writes
   // ------------------------------------------------------------------------
   // Next ODR value for plain write, set and clear aliases
   always_comb begin
      odr_next = odr;
      if (wr_en) begin
         case (wb_adr_i)
            ADR_ODR: odr_next = wdata;
            ADR_SET: odr_next = odr | wdata;
            ADR_CLR: odr_next = odr & ~wdata;
            default: odr_next = odr;
         endcase
      end else begin
         odr_next = odr;
      end
   end

   // Write-one-to-clear mask for the interrupt status register
   always_comb begin
      w1c_mask = PIN_ZERO;
      if (wr_en && (wb_adr_i == ADR_ISR)) begin
         w1c_mask = wdata;
      end else begin
         w1c_mask = PIN_ZERO;
      end
   end

   // Control registers: ODR, DIR, RISE, FALL
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         odr     <= PIN_ZERO;
         dir     <= PIN_ZERO;
         rise_en <= PIN_ZERO;
         fall_en <= PIN_ZERO;
      end else begin
         odr <= odr_next;
         if (wr_en) begin
            case (wb_adr_i)
               ADR_DIR:  dir     <= wdata;
               ADR_RISE: rise_en <= wdata;
               ADR_FALL: fall_en <= wdata;
               default:  ;
            endcase
         end
      end
   end

   // Interrupt status: clear is applied before new events are OR-ed in, so
   // an edge landing in the same cycle as its W1C is not lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         isr <= PIN_ZERO;
      end else begin
         isr <= (isr & ~w1c_mask) | rise_evt | fall_evt;
      end
   end

   // Registered interrupt line, one cycle behind the status register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq <= 1'b0;
      end else begin
         irq <= |isr;
      end
   end

   // ------------------------------------------------------------------------
   // Read path
   // ------------------------------------------------------------------------
   // Read multiplexer; unmapped addresses return all ones
   always_comb begin
      read_data = 32'hFFFF_FFFF;
      case (wb_adr_i)
         ADR_IDR:  read_data = pad32(sync_pins);
         ADR_ODR:  read_data = pad32(odr);
         ADR_DIR:  read_data = pad32(dir);
         ADR_SET:  read_data = 32'h0000_0000;
         ADR_CLR:  read_data = 32'h0000_0000;
         ADR_RISE: read_data = pad32(rise_en);
         ADR_FALL: read_data = pad32(fall_en);
         ADR_ISR:  read_data = pad32(isr);
         default:  read_data = 32'hFFFF_FFFF;
      endcase
   end

   // Acknowledge and read data; both register on the access cycle so data
   // is valid exactly while ack is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_ack_o <= 1'b0;
         wb_dat_o <= 32'h0000_0000;
      end else if (access) begin
         wb_ack_o <= 1'b1;
         if (wb_we_i) begin
            wb_dat_o <= 32'h0000_0000;
         end else begin
            wb_dat_o <= read_data;
         end
      end else begin
         wb_ack_o <= 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Pin outputs
   // ------------------------------------------------------------------------
   assign gpio_o  = odr;
   assign gpio_oe = dir;

endmodule

// File: tb/tb_gpio_controller_v2.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_gpio_controller_v2
//
// Directed bench for gpio_controller_v2 (BASE_ADDR 32'h8000_1000,
// GPIO_WIDTH 16, SYNC_STAGES 2). Inputs change 1 ns after a rising edge and
// outputs are sampled 1 ns after a rising edge.
// ---------------------------------------------------------------------------
module tb_gpio_controller_v2;

   localparam logic [31:0] BASE = 32'h8000_1000;

   logic        clk;
   logic        rst_n;
   logic [31:0] wb_dat_i;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_adr_i;
   logic        wb_we_i;
   logic        wb_stb_i;
   logic        wb_cyc_i;
   logic        wb_ack_o;
   logic [15:0] gpio_i;
   logic [15:0] gpio_o;
   logic [15:0] gpio_oe;
   logic        irq;

   int          checks;
   int          errors;
   logic [31:0] rd;

   gpio_controller_v2 #(
      .BASE_ADDR   (BASE),
      .GPIO_WIDTH  (16),
      .SYNC_STAGES (2)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wb_dat_i (wb_dat_i),
      .wb_dat_o (wb_dat_o),
      .wb_adr_i (wb_adr_i),
      .wb_we_i  (wb_we_i),
      .wb_stb_i (wb_stb_i),
      .wb_cyc_i (wb_cyc_i),
      .wb_ack_o (wb_ack_o),
      .gpio_i   (gpio_i),
      .gpio_o   (gpio_o),
      .gpio_oe  (gpio_oe),
      .irq      (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single Wishbone access; returns the data present while ack is high.
   task automatic wb_xfer(input logic we, input logic [31:0] adr,
                          input logic [31:0] wdat, output logic [31:0] rdat);
      logic got;
      got = 1'b0;
      @(posedge clk); #1;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
      wb_adr_i = adr;  wb_dat_i = wdat;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (wb_ack_o) begin
            got = 1'b1;
            break;
         end
      end
      rdat = wb_dat_o;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL bus_timeout adr=%h: no ack within 8 cycles", adr);
      end
   endtask

   task automatic test_reset();
      logic [31:0] exp_tab [8];
      rst_n = 1'b0; gpio_i = 16'h5A31;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      wb_adr_i = 32'h0; wb_dat_i = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({wb_ack_o, irq, gpio_o, gpio_oe, wb_dat_o} !== 66'h0) begin
         errors++;
         $display("FAIL reset_outputs ack=%b irq=%b o=%h oe=%h dat=%h expected all 0",
                  wb_ack_o, irq, gpio_o, gpio_oe, wb_dat_o);
      end
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      exp_tab[0] = 32'h0000_5A31;
      for (int k = 1; k < 8; k++) exp_tab[k] = 32'h0;
      for (int k = 0; k < 8; k++) begin
         wb_xfer(1'b0, BASE + 32'(k * 4), 32'h0, rd);
         checks++;
         if (rd !== exp_tab[k]) begin
            errors++;
            $display("FAIL reset_read off=%0h got=%h expected=%h", k * 4, rd, exp_tab[k]);
         end
      end
      wb_xfer(1'b0, BASE + 32'h20, 32'h0, rd);
      checks++;
      if (rd !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL unmapped_read got=%h expected=ffffffff", rd);
      end
      @(posedge clk); #1;
      checks++;
      if (wb_ack_o !== 1'b0) begin
         errors++;
         $display("FAIL ack_one_cycle got=%b expected=0", wb_ack_o);
      end
   endtask

   task automatic test_odr();
      wb_xfer(1'b1, BASE + 32'h04, 32'h0000_A5A5, rd);
      wb_xfer(1'b1, BASE + 32'h0C, 32'h0000_000F, rd);   // A5A5 | 000F = A5AF
      wb_xfer(1'b1, BASE + 32'h10, 32'h0000_0A00, rd);   // bits 11,9 already 0 -> A5AF
      wb_xfer(1'b0, BASE + 32'h04, 32'h0, rd);
      checks++;
      if (rd !== 32'h0000_A5AF) begin
         errors++;
         $display("FAIL odr_set_clr got=%h expected=0000a5af", rd);
      end
      wb_xfer(1'b1, BASE + 32'h10, 32'h0000_0500, rd);   // clear bits 10,8 -> A0AF
      wb_xfer(1'b0, BASE + 32'h04, 32'h0, rd);
      checks++;
      if (rd !== 32'h0000_A0AF) begin
         errors++;
         $display("FAIL odr_clr got=%h expected=0000a0af", rd);
      end
      checks++;
      if (gpio_o !== 16'hA0AF) begin
         errors++;
         $display("FAIL gpio_o got=%h expected=a0af", gpio_o);
      end
      wb_xfer(1'b0, BASE + 32'h0C, 32'h0, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL set_reads_zero got=%h expected=0", rd);
      end
   endtask

   task automatic test_dir();
      wb_xfer(1'b1, BASE + 32'h08, 32'hFFFF_00FF, rd);
      checks++;
      if (gpio_oe !== 16'h00FF) begin
         errors++;
         $display("FAIL gpio_oe got=%h expected=00ff", gpio_oe);
      end
      wb_xfer(1'b0, BASE + 32'h08, 32'h0, rd);
      checks++;
      if (rd !== 32'h0000_00FF) begin
         errors++;
         $display("FAIL dir_upper_bits got=%h expected=000000ff", rd);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] acks;
      logic [31:0] first_dat;
      @(posedge clk); #1;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = BASE + 32'h04;
      first_dat = 32'h0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         acks[i] = wb_ack_o;
         if (i == 0) first_dat = wb_dat_o;
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      checks++;
      if (acks !== 4'b0101) begin
         errors++;
         $display("FAIL back_to_back_ack got=%b expected=0101 (lsb first)", acks);
      end
      checks++;
      if (first_dat !== 32'h0000_A0AF) begin
         errors++;
         $display("FAIL back_to_back_data got=%h expected=0000a0af", first_dat);
      end
   endtask

   task automatic test_rise_irq();
      logic [3:0] irq_seen;
      wb_xfer(1'b1, BASE + 32'h14, 32'h0000_0008, rd);
      @(posedge clk); #1;
      gpio_i[3] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         irq_seen[i] = irq;
      end
      checks++;
      if (irq_seen !== 4'b1000) begin
         errors++;
         $display("FAIL rise_irq_timing got=%b expected=1000 (edge1 at lsb)", irq_seen);
      end
      wb_xfer(1'b0, BASE + 32'h1C, 32'h0, rd);
      checks++;
      if (rd !== 32'h0000_0008) begin
         errors++;
         $display("FAIL rise_isr got=%h expected=00000008", rd);
      end
      wb_xfer(1'b0, BASE + 32'h00, 32'h0, rd);
      checks++;
      if (rd !== 32'h0000_5A39) begin
         errors++;
         $display("FAIL idr_after_rise got=%h expected=00005a39", rd);
      end
      wb_xfer(1'b1, BASE + 32'h1C, 32'h0000_0008, rd);
      @(posedge clk); #1;
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL w1c_irq got=%b expected=0", irq);
      end
      wb_xfer(1'b0, BASE + 32'h1C, 32'h0, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL w1c_isr got=%h expected=0", rd);
      end
   endtask

   task automatic test_fall_w1c_collision();
      wb_xfer(1'b1, BASE + 32'h18, 32'h0000_0001, rd);
      @(posedge clk); #1;
      gpio_i[0] = 1'b0;                  // first falling edge sets ISR[0]
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL fall_irq got=%b expected=1", irq);
      end
      gpio_i[0] = 1'b1;                  // rising edge, not enabled
      repeat (4) @(posedge clk);
      #1;
      // Second fall: the event reaches ISR on the third edge after the pin
      // change, the same edge that accepts the W1C driven below.
      gpio_i[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
      wb_adr_i = BASE + 32'h1C; wb_dat_i = 32'h0000_0001;
      @(posedge clk); #1;
      checks++;
      if (wb_ack_o !== 1'b1) begin
         errors++;
         $display("FAIL collision_ack got=%b expected=1", wb_ack_o);
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL collision_irq got=%b expected=1", irq);
      end
      wb_xfer(1'b0, BASE + 32'h1C, 32'h0, rd);
      checks++;
      if (rd !== 32'h0000_0001) begin
         errors++;
         $display("FAIL collision_isr got=%h expected=00000001", rd);
      end
   endtask

   task automatic test_async_reset();
      @(posedge clk); #1;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = BASE + 32'h04;
      @(posedge clk); #1;
      checks++;
      if (wb_ack_o !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_ack got=%b expected=1", wb_ack_o);
      end
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({wb_ack_o, irq, gpio_o, wb_dat_o} !== 50'h0) begin
         errors++;
         $display("FAIL async_reset ack=%b irq=%b o=%h dat=%h expected all 0",
                  wb_ack_o, irq, gpio_o, wb_dat_o);
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      rst_n = 1'b1;
      wb_xfer(1'b0, BASE + 32'h04, 32'h0, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL odr_after_reset got=%h expected=0", rd);
      end
      wb_xfer(1'b0, BASE + 32'h1C, 32'h0, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL isr_after_reset got=%h expected=0", rd);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_odr();
      test_dir();
      test_back_to_back();
      test_rise_irq();
      test_fall_w1c_collision();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
